// File: rtl/div_pkg.sv
// Shared definitions for the M-extension divide path.
// Op codes, issue FSM encoding and the reuse entry layout.
package div_pkg;

  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REM  = 4'b1110;
  localparam logic [3:0] OP_REMU = 4'b1111;

  localparam logic [3:0] IS_DIV_MASK = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } div_state_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } reuse_t;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op & IS_DIV_MASK) == IS_DIV_MASK;
  endfunction

endpackage

// File: rtl/div_issue_ctrl_reuse.sv
// One-entry divide result cache: stores the last completed
// divide and flags an exact op/operand match for reuse.
module div_reuse_entry
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_i,
  input  logic        wr_i,
  input  reuse_t      wr_data_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        hit_o,
  output logic [31:0] res_o
);

  logic   valid_q;
  reuse_t ent_q;

  // Entry is written on every completed divide; only reset clears it.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
    end else if (wr_i) begin
      valid_q <= 1'b1;
      ent_q   <= wr_data_i;
    end
  end

  // Exact match on op and both operands.
  always_comb begin
    hit_o = valid_q
          & (ent_q.op == op_i)
          & (ent_q.a  == a_i)
          & (ent_q.b  == b_i);
    res_o = ent_q.res;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the divide unit.
// Optional result reuse enabled by defining DIV_REUSE_EN.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic [3:0]  ex_div_op_i,
  input  logic [31:0] ex_rs1_i,
  input  logic [31:0] ex_rs2_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] result_o,
  output logic        result_valid_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  output logic [3:0]  div_op_o,
  output logic        div_valid_o,
  input  logic        div_ready_i,
  input  logic [31:0] div_result_i,
  output logic        timeout_o
);

  div_state_e  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        tmo_q, tmo_d;

  logic        start;
  logic        hit;
  logic [31:0] hit_res;

  assign start = ex_valid_i & is_div_op(ex_div_op_i) & ~flush_i;

`ifdef DIV_REUSE_EN
  reuse_t wr_data;
  assign wr_data = '{op: op_q, a: a_q, b: b_q, res: res_q};

  div_reuse_entry u_reuse (
    .clk       (clk),
    .rst_i     (rst_n),
    .wr_i      (state_q == ST_DONE),
    .wr_data_i (wr_data),
    .op_i      (ex_div_op_i),
    .a_i       (ex_rs1_i),
    .b_i       (ex_rs2_i),
    .hit_o     (hit),
    .res_o     (hit_res)
  );
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

  // State and datapath registers; reset is asynchronous, active-high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state: issue, wait for ready, drain killed requests.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    if ((state_q == ST_REQ || state_q == ST_DRAIN)
        && !div_ready_i
        && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))
      tmo_d = 1'b1;
    if (cnt_q < CNT_W'(TIMEOUT_CYCLES))
      cnt_d = cnt_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (start) begin
          a_d  = ex_rs1_i;
          b_d  = ex_rs2_i;
          op_d = ex_div_op_i;
          if (hit) begin
            res_d   = hit_res;
            state_d = ST_DONE;
          end else begin
            cnt_d   = '0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (div_ready_i && !flush_i) begin
          res_d   = div_result_i;
          state_d = ST_DONE;
        end else if (flush_i && !div_ready_i) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else if (flush_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        cnt_d   = cnt_q;
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (div_ready_i)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    div_valid_o    = (state_q == ST_REQ) | (state_q == ST_DRAIN);
    result_valid_o = (state_q == ST_DONE);
    result_o       = (state_q == ST_DONE) ? res_q : '0;
    stall_o        = start & (state_q != ST_DONE);
    div_a_o        = a_q;
    div_b_o        = b_q;
    div_op_o       = op_q;
    timeout_o      = tmo_q;
  end

endmodule
